dcache_dm: RTL and testbench
============================

Name: dcache_dm

Overview:
Direct-mapped, write-through, no-write-allocate L1 data cache. It is the responder for the load/store unit's dcache request interface: it takes the request registered at end of execute, which may be killed during the memory stage. It returns read data or a nack registered into writeback. Misses run a line refill over a simple word-wide memory port; nacked requests are replayed by the LSU queues.

Parameters:
WIDTH_MEM, 4, word-address width (matches LSU WIDTH_MEM)
WIDTH_OFF, 1, log2 words per line
WIDTH_IDX, 2, log2 number of lines; tag width = WIDTH_MEM-WIDTH_IDX-WIDTH_OFF, must be >=1
WIDTH_DATA, 32, data word width

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_val  in  1  request valid (memory stage)
i_we  in  1  1=store, 0=load
i_addr  in  WIDTH_MEM  word address
i_data  in  WIDTH_DATA  store data
i_kill  in  1  same-cycle squash of current request
o_data  out  WIDTH_DATA  load data (writeback stage)
o_nack  out  1  request not serviced; replay
mem_o_req  out  1  memory request
mem_o_we  out  1  memory write
mem_o_addr  out  WIDTH_MEM  memory word address
mem_o_data  out  WIDTH_DATA  memory write data
mem_i_ack  in  1  request accepted this cycle
mem_i_rval  in  1  read beat valid (in order, any latency >=1)
mem_i_rdata  in  WIDTH_DATA  read beat data

Behaviour:
- Clock i_clk; reset i_rst_n asynchronous, active-low. One clock domain.
- Reset: state IDLE, all line valid bits 0, counters 0, o_data=0, o_nack=0. Data and tag arrays are not reset.
- Live request: act = i_val & ~i_kill. A killed request has no side effects: no array write, no mem request, no FSM change, and o_nack=0 next cycle.
- Latency: o_data/o_nack are registered. A request in cycle N responds in cycle N+1. o_data is meaningful only for a live load with o_nack=0. When there is no live request, o_nack=0.
- FSM states: IDLE, FILL.
- IDLE, live load, hit (valid & tag match): o_data <= line word; o_nack <= 0.
- IDLE, live load, miss:
  - o_nack <= 1.
  - Clear the line's valid bit; write the new tag; latch the line base address.
  - Reset req_cnt/rsp_cnt; go to FILL.
  - No mem request this cycle.
- IDLE, live store:
  - Drive mem_o_req=1, mem_o_we=1, addr/data combinationally.
  - If mem_i_ack: o_nack <= 0, and on a hit the cached word is updated at the edge.
  - If no ack: o_nack <= 1, no array update.
  - A store miss never allocates.
- FILL:
  - While req_cnt < 2^WIDTH_OFF: drive mem_o_req=1, mem_o_we=0, addr = base+req_cnt. Increment req_cnt on mem_i_ack.
  - On each mem_i_rval: write the beat to word rsp_cnt of the line, then increment rsp_cnt.
  - When the last beat is received: set valid and return to IDLE at that edge.
  - Every live request during FILL, including one in the last-beat cycle, gets o_nack <= 1 with no side effects.
  - A kill during FILL does not abort the refill.
- Counters are WIDTH_OFF+1 bits wide, so the terminal count is exact and does not wrap.
- Address arithmetic is modulo 2^WIDTH_MEM; the base is line-aligned, so there is no overflow.
- A reset asserted mid-FILL returns to IDLE with all lines invalid. Memory shares the reset, so no stale beats arrive.
- mem_o_req=0 whenever nothing above drives it.

Decomposition:
- Shared package/include: FSM state encodings (S_IDLE, S_FILL), plus tag/index/offset slice helpers derived from WIDTH_MEM/WIDTH_IDX/WIDTH_OFF.
- One natural sub-module: the line data array as the existing `ram` primitive, WIDTH_ADDR=WIDTH_IDX+WIDTH_OFF, with the write port muxed between refill beat and store hit.
- Tags and valid bits stay in flops in the top module.

Test Plan:
- Reset then load addr 4'h5 -> o_nack=1 next cycle; memory sees reads 4'h4, 4'h5; after beats 0xA0/0xA1, replay of 4'h5 gives o_nack=0, o_data=0xA1.
- Load hit 4'h4, then store 4'h4 data 0x55 with ack=1 -> no nack; mem write 4'h4/0x55; next load of 4'h4 returns 0x55.
- Store to uncached 4'hC with ack=0 -> o_nack=1, no mem write counted; the same store retried with ack=1 completes, and a load of 4'hC then misses (no allocate).
- Load miss with i_kill=1 -> o_nack=0, mem_o_req stays 0, state stays IDLE; a later unkilled load of the same address misses normally.
- Request issued in the same cycle as the final fill beat -> o_nack=1; the same request one cycle later hits.
- Reset asserted after the first fill beat -> o_nack=0, state IDLE; a subsequent load of any previously filled address misses.

Source files
------------

// File: rtl/dcache_dm_pkg.sv
// Shared definitions for the direct-mapped data cache.
// Contents:
//   DEF_*    default geometry used by the cache, its interface and its data array
//   state_t  refill FSM encoding (S_IDLE, S_FILL)
//   addr_*   helpers that split a word address into tag / index / offset / line base
package dcache_dm_pkg;

    localparam int DEF_WIDTH_MEM  = 4;
    localparam int DEF_WIDTH_OFF  = 1;
    localparam int DEF_WIDTH_IDX  = 2;
    localparam int DEF_WIDTH_DATA = 32;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    // Word offset inside a line (low w_off bits).
    function automatic logic [31:0] addr_off(input logic [31:0] addr, input int w_off);
        return addr & ((32'd1 << w_off) - 32'd1);
    endfunction

    // Line index (the w_idx bits just above the offset).
    function automatic logic [31:0] addr_idx(input logic [31:0] addr, input int w_off,
                                             input int w_idx);
        return (addr >> w_off) & ((32'd1 << w_idx) - 32'd1);
    endfunction

    // Tag (everything above index and offset).
    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int w_off,
                                             input int w_idx);
        return addr >> (w_off + w_idx);
    endfunction

    // Address of word 0 of the line holding addr.
    function automatic logic [31:0] addr_base(input logic [31:0] addr, input int w_off);
        return addr & ~((32'd1 << w_off) - 32'd1);
    endfunction

endpackage

// File: rtl/dcache_dm_if.sv
// Request/response and memory-port bundle for the data cache.
// Request side : i_val, i_we, i_addr, i_data, i_kill -> o_data, o_nack
// Memory side  : mem_o_req, mem_o_we, mem_o_addr, mem_o_data <- mem_i_ack, mem_i_rval, mem_i_rdata
// Modports     : slave = the cache, master = the LSU plus backing memory.
interface dcache_dm_if
    import dcache_dm_pkg::*;
#(
    parameter int WIDTH_MEM  = DEF_WIDTH_MEM,
    parameter int WIDTH_DATA = DEF_WIDTH_DATA
);

    logic                  i_val;
    logic                  i_we;
    logic [WIDTH_MEM-1:0]  i_addr;
    logic [WIDTH_DATA-1:0] i_data;
    logic                  i_kill;
    logic [WIDTH_DATA-1:0] o_data;
    logic                  o_nack;

    logic                  mem_o_req;
    logic                  mem_o_we;
    logic [WIDTH_MEM-1:0]  mem_o_addr;
    logic [WIDTH_DATA-1:0] mem_o_data;
    logic                  mem_i_ack;
    logic                  mem_i_rval;
    logic [WIDTH_DATA-1:0] mem_i_rdata;

    modport slave (
        input  i_val, i_we, i_addr, i_data, i_kill,
        output o_data, o_nack,
        output mem_o_req, mem_o_we, mem_o_addr, mem_o_data,
        input  mem_i_ack, mem_i_rval, mem_i_rdata
    );

    modport master (
        output i_val, i_we, i_addr, i_data, i_kill,
        input  o_data, o_nack,
        input  mem_o_req, mem_o_we, mem_o_addr, mem_o_data,
        output mem_i_ack, mem_i_rval, mem_i_rdata
    );

endinterface

// File: rtl/dcache_dm_ram.sv
// Line data array: one synchronous write port, one asynchronous read port.
// Ports: clk, we/waddr/wdata (write), raddr -> rdata (read). Contents are not reset.
module dcache_dm_ram
    import dcache_dm_pkg::*;
#(
    parameter int WIDTH_ADDR = DEF_WIDTH_IDX + DEF_WIDTH_OFF,
    parameter int WIDTH_DATA = DEF_WIDTH_DATA
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [WIDTH_ADDR-1:0] waddr,
    input  logic [WIDTH_DATA-1:0] wdata,
    input  logic [WIDTH_ADDR-1:0] raddr,
    output logic [WIDTH_DATA-1:0] rdata
);

    logic [WIDTH_DATA-1:0] mem [1 << WIDTH_ADDR];

    // Single write port; the caller decides between refill beats and store hits.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache.
// Ports: i_clk, i_rst_n (async active-low), bus (dcache_dm_if.slave: LSU request
// with registered o_data/o_nack response, plus word-wide memory port).
// Load misses nack and refill the whole line; every request during a refill nacks.
module dcache_dm
    import dcache_dm_pkg::*;
#(
    parameter int WIDTH_MEM  = DEF_WIDTH_MEM,
    parameter int WIDTH_OFF  = DEF_WIDTH_OFF,
    parameter int WIDTH_IDX  = DEF_WIDTH_IDX,
    parameter int WIDTH_DATA = DEF_WIDTH_DATA
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    dcache_dm_if.slave bus
);

    localparam int WIDTH_TAG  = WIDTH_MEM - WIDTH_IDX - WIDTH_OFF;
    localparam int WIDTH_ADDR = WIDTH_IDX + WIDTH_OFF;
    localparam int LINES      = 1 << WIDTH_IDX;
    localparam int WORDS      = 1 << WIDTH_OFF;

    // One extra bit so the terminal count equals WORDS exactly.
    typedef logic [WIDTH_OFF:0] cnt_t;
    localparam cnt_t CNT_WORDS = cnt_t'(WORDS);
    localparam cnt_t CNT_LAST  = cnt_t'(WORDS - 1);

    state_t                state;
    logic [LINES-1:0]      valid;
    logic [WIDTH_TAG-1:0]  tag_arr [LINES];
    logic [WIDTH_MEM-1:0]  base;
    cnt_t                  req_cnt;
    cnt_t                  rsp_cnt;
    logic [WIDTH_DATA-1:0] rsp_data;
    logic                  rsp_nack;

    logic                  act;
    logic                  hit;
    logic                  load_miss;
    logic                  store_hit_ack;
    logic                  fill_pending;
    logic [WIDTH_IDX-1:0]  req_idx;
    logic [WIDTH_IDX-1:0]  fill_idx;
    logic [WIDTH_OFF-1:0]  req_off;
    logic [WIDTH_TAG-1:0]  req_tag;
    logic                  ram_we;
    logic [WIDTH_ADDR-1:0] ram_waddr;
    logic [WIDTH_ADDR-1:0] ram_raddr;
    logic [WIDTH_DATA-1:0] ram_wdata;
    logic [WIDTH_DATA-1:0] ram_rdata;

    assign act       = bus.i_val & ~bus.i_kill;
    assign req_idx   = WIDTH_IDX'(addr_idx(32'(bus.i_addr), WIDTH_OFF, WIDTH_IDX));
    assign req_off   = WIDTH_OFF'(addr_off(32'(bus.i_addr), WIDTH_OFF));
    assign req_tag   = WIDTH_TAG'(addr_tag(32'(bus.i_addr), WIDTH_OFF, WIDTH_IDX));
    assign fill_idx  = WIDTH_IDX'(addr_idx(32'(base), WIDTH_OFF, WIDTH_IDX));
    assign ram_raddr = {req_idx, req_off};

    assign hit           = valid[req_idx] && (tag_arr[req_idx] == req_tag);
    assign load_miss     = (state == S_IDLE) && act && !bus.i_we && !hit;
    assign store_hit_ack = (state == S_IDLE) && act && bus.i_we && bus.mem_i_ack && hit;
    assign fill_pending  = (state == S_FILL) && (req_cnt < CNT_WORDS);

    assign bus.o_data = rsp_data;
    assign bus.o_nack = rsp_nack;

    // Data array write port: refill beats own it during FILL, acked store hits in IDLE.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = ram_raddr;
        ram_wdata = bus.i_data;
        if (state == S_FILL) begin
            ram_we    = bus.mem_i_rval;
            ram_waddr = {fill_idx, rsp_cnt[WIDTH_OFF-1:0]};
            ram_wdata = bus.mem_i_rdata;
        end else if (store_hit_ack) begin
            ram_we = 1'b1;
        end
    end

    // Memory port: refill reads take priority; stores write through only from IDLE.
    always_comb begin
        bus.mem_o_req  = 1'b0;
        bus.mem_o_we   = 1'b0;
        bus.mem_o_addr = bus.i_addr;
        bus.mem_o_data = bus.i_data;
        if (fill_pending) begin
            bus.mem_o_req  = 1'b1;
            bus.mem_o_addr = base + WIDTH_MEM'(req_cnt);
        end else if ((state == S_IDLE) && act && bus.i_we) begin
            bus.mem_o_req = 1'b1;
            bus.mem_o_we  = 1'b1;
        end
    end

    // Tag array is not reset; the valid bits alone say whether a tag means anything.
    always_ff @(posedge i_clk) begin
        if (load_miss) begin
            tag_arr[req_idx] <= req_tag;
        end
    end

    // Refill FSM with registered load response; a line stays invalid until its last beat.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_IDLE;
            valid    <= '0;
            base     <= '0;
            req_cnt  <= '0;
            rsp_cnt  <= '0;
            rsp_data <= '0;
            rsp_nack <= 1'b0;
        end else begin
            rsp_nack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (act) begin
                        if (bus.i_we) begin
                            rsp_nack <= ~bus.mem_i_ack;
                        end else if (hit) begin
                            rsp_data <= ram_rdata;
                        end else begin
                            rsp_nack         <= 1'b1;
                            valid[req_idx]   <= 1'b0;
                            base             <= WIDTH_MEM'(addr_base(32'(bus.i_addr), WIDTH_OFF));
                            req_cnt          <= '0;
                            rsp_cnt          <= '0;
                            state            <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (act) begin
                        rsp_nack <= 1'b1;
                    end
                    if (fill_pending && bus.mem_i_ack) begin
                        req_cnt <= req_cnt + 1'b1;
                    end
                    if (bus.mem_i_rval) begin
                        rsp_cnt <= rsp_cnt + 1'b1;
                        if (rsp_cnt == CNT_LAST) begin
                            valid[fill_idx] <= 1'b1;
                            state           <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    dcache_dm_ram #(
        .WIDTH_ADDR (WIDTH_ADDR),
        .WIDTH_DATA (WIDTH_DATA)
    ) u_ram (
        .clk   (i_clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_dcache_dm.sv
// Testbench for dcache_dm: directed requests, a backing memory that answers the
// cache's memory port, and a line-level cache model checked every cycle.
module tb_dcache_dm;

    localparam int WORDS = 2;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;

    always #5 i_clk = ~i_clk;

    dcache_dm_if #(.WIDTH_MEM(4), .WIDTH_DATA(32)) bus ();

    dcache_dm dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // Backing memory and its pending read beats.
    logic [31:0] mem_model [16];
    logic [3:0]  rd_q[$];
    logic [3:0]  rd_log[$];
    int          wr_count = 0;
    bit          hold_beats = 1'b0;

    // Cache model: which line holds which tag, and whether a refill is outstanding.
    bit          line_valid [4];
    int          line_tag [4];
    bit          busy;
    int          beats;
    int          fill_line;
    logic [3:0]  exp_reads[$];
    bit          exp_nack;
    bit          exp_dchk;
    logic [31:0] exp_data;

    bit live;
    int a;
    int idx;
    int tg;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %h required %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit val, input bit we, input logic [3:0] addr,
                                 input logic [31:0] data, input bit kill, input bit ack);
        @(posedge i_clk);
        #1;
        bus.i_val     = val;
        bus.i_we      = we;
        bus.i_addr    = addr;
        bus.i_data    = data;
        bus.i_kill    = kill;
        bus.mem_i_ack = ack;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic waitFill(input string name);
        int n = 0;
        while (busy && n < 30) begin
            idleCycle();
            n++;
        end
        checkOutput({name, "_fill_done"}, {31'b0, busy}, 32'd0);
    endtask

    // Backing memory returns queued read beats one per cycle unless held back.
    always @(posedge i_clk) begin
        #1;
        if (i_rst_n && !hold_beats && rd_q.size() > 0) begin
            bus.mem_i_rval  = 1'b1;
            bus.mem_i_rdata = mem_model[rd_q[0]];
        end else begin
            bus.mem_i_rval  = 1'b0;
            bus.mem_i_rdata = 32'h0;
        end
    end

    // Compare, then advance memory and cache model for the coming edge.
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 4; i++) line_valid[i] = 1'b0;
            busy     = 1'b0;
            beats    = 0;
            exp_nack = 1'b0;
            exp_dchk = 1'b0;
            rd_q.delete();
            exp_reads.delete();
            checkOutput("reset_nack", {31'b0, bus.o_nack}, 32'd0);
            checkOutput("reset_req", {31'b0, bus.mem_o_req}, 32'd0);
        end else begin
            checkOutput("o_nack", {31'b0, bus.o_nack}, {31'b0, exp_nack});
            if (exp_dchk) checkOutput("o_data", bus.o_data, exp_data);

            live = bus.i_val && !bus.i_kill;
            if (busy && exp_reads.size() > 0) begin
                checkOutput("rd_req", {31'b0, bus.mem_o_req}, 32'd1);
                checkOutput("rd_we", {31'b0, bus.mem_o_we}, 32'd0);
                checkOutput("rd_addr", {28'b0, bus.mem_o_addr}, {28'b0, exp_reads[0]});
                if (bus.mem_i_ack) void'(exp_reads.pop_front());
            end else if (!busy && live && bus.i_we) begin
                checkOutput("wr_req", {31'b0, bus.mem_o_req}, 32'd1);
                checkOutput("wr_we", {31'b0, bus.mem_o_we}, 32'd1);
                checkOutput("wr_addr", {28'b0, bus.mem_o_addr}, {28'b0, bus.i_addr});
                checkOutput("wr_data", bus.mem_o_data, bus.i_data);
            end else begin
                checkOutput("idle_req", {31'b0, bus.mem_o_req}, 32'd0);
            end

            if (bus.mem_o_req && bus.mem_i_ack) begin
                if (bus.mem_o_we) begin
                    mem_model[bus.mem_o_addr] = bus.mem_o_data;
                    wr_count++;
                end else begin
                    rd_q.push_back(bus.mem_o_addr);
                    rd_log.push_back(bus.mem_o_addr);
                end
            end

            if (busy) begin
                exp_nack = live;
                exp_dchk = 1'b0;
                if (bus.mem_i_rval) begin
                    beats++;
                    if (beats == WORDS) begin
                        line_valid[fill_line] = 1'b1;
                        busy = 1'b0;
                    end
                end
            end else if (live && bus.i_we) begin
                exp_nack = !bus.mem_i_ack;
                exp_dchk = 1'b0;
            end else if (live) begin
                a   = int'(bus.i_addr);
                idx = (a / 2) % 4;
                tg  = a / 8;
                if (line_valid[idx] && line_tag[idx] == tg) begin
                    exp_nack = 1'b0;
                    exp_dchk = 1'b1;
                    exp_data = mem_model[a];
                end else begin
                    exp_nack        = 1'b1;
                    exp_dchk        = 1'b0;
                    line_valid[idx] = 1'b0;
                    line_tag[idx]   = tg;
                    busy            = 1'b1;
                    beats           = 0;
                    fill_line       = idx;
                    exp_reads.push_back(4'((a / 2) * 2));
                    exp_reads.push_back(4'((a / 2) * 2 + 1));
                end
            end else begin
                exp_nack = 1'b0;
                exp_dchk = 1'b0;
            end

            if (bus.mem_i_rval && rd_q.size() > 0) void'(rd_q.pop_front());
        end
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.i_val     = 1'b0;
        bus.i_we      = 1'b0;
        bus.i_addr    = 4'h0;
        bus.i_data    = 32'h0;
        bus.i_kill    = 1'b0;
        bus.mem_i_ack = 1'b1;
        for (int i = 0; i < 16; i++) mem_model[i] = 32'h9C + i;

        repeat (2) @(negedge i_clk);
        checkOutput("rst_o_data", bus.o_data, 32'h0);
        checkOutput("rst_o_nack", {31'b0, bus.o_nack}, 32'd0);
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;

        // Cold load miss on 5, refill of 4/5, replay hits.
        applyStimulus(1, 0, 4'h5, 0, 0, 1);
        idleCycle();
        @(negedge i_clk);
        checkOutput("t1_miss_nack", {31'b0, bus.o_nack}, 32'd1);
        waitFill("t1");
        checkOutput("t1_rd_count", rd_log.size(), 32'd2);
        checkOutput("t1_rd_first", {28'b0, rd_log[0]}, 32'h4);
        checkOutput("t1_rd_second", {28'b0, rd_log[1]}, 32'h5);
        applyStimulus(1, 0, 4'h5, 0, 0, 1);
        idleCycle();
        @(negedge i_clk);
        checkOutput("t1_hit_nack", {31'b0, bus.o_nack}, 32'd0);
        checkOutput("t1_hit_data", bus.o_data, 32'hA1);

        // Load hit then store hit with ack; reload sees the new word.
        applyStimulus(1, 0, 4'h4, 0, 0, 1);
        applyStimulus(1, 1, 4'h4, 32'h55, 0, 1);
        @(negedge i_clk);
        checkOutput("t2_load_data", bus.o_data, 32'hA0);
        idleCycle();
        @(negedge i_clk);
        checkOutput("t2_store_nack", {31'b0, bus.o_nack}, 32'd0);
        checkOutput("t2_wr_count", wr_count, 32'd1);
        checkOutput("t2_mem_word", mem_model[4], 32'h55);
        applyStimulus(1, 0, 4'h4, 0, 0, 1);
        idleCycle();
        @(negedge i_clk);
        checkOutput("t2_reload_data", bus.o_data, 32'h55);

        // Store miss without ack nacks; acked retry writes; no allocation.
        applyStimulus(1, 1, 4'hC, 32'h77, 0, 0);
        idleCycle();
        @(negedge i_clk);
        checkOutput("t3_noack_nack", {31'b0, bus.o_nack}, 32'd1);
        checkOutput("t3_noack_wr_count", wr_count, 32'd1);
        applyStimulus(1, 1, 4'hC, 32'h77, 0, 1);
        idleCycle();
        @(negedge i_clk);
        checkOutput("t3_ack_nack", {31'b0, bus.o_nack}, 32'd0);
        checkOutput("t3_ack_wr_count", wr_count, 32'd2);
        applyStimulus(1, 0, 4'hC, 0, 0, 1);
        idleCycle();
        @(negedge i_clk);
        checkOutput("t3_no_allocate", {31'b0, bus.o_nack}, 32'd1);
        waitFill("t3");
        applyStimulus(1, 0, 4'hC, 0, 0, 1);
        idleCycle();
        @(negedge i_clk);
        checkOutput("t3_refilled_data", bus.o_data, 32'h77);

        // Killed load leaves no trace; the unkilled retry misses.
        applyStimulus(1, 0, 4'hA, 0, 1, 1);
        idleCycle();
        @(negedge i_clk);
        checkOutput("t4_kill_nack", {31'b0, bus.o_nack}, 32'd0);
        checkOutput("t4_kill_req", {31'b0, bus.mem_o_req}, 32'd0);
        applyStimulus(1, 0, 4'hA, 0, 0, 1);
        idleCycle();
        @(negedge i_clk);
        checkOutput("t4_retry_nack", {31'b0, bus.o_nack}, 32'd1);
        waitFill("t4");
        applyStimulus(1, 0, 4'hA, 0, 0, 1);
        idleCycle();
        @(negedge i_clk);
        checkOutput("t4_hit_data", bus.o_data, 32'hA6);

        // Request in the final-beat cycle nacks; one cycle later it hits.
        hold_beats = 1'b1;
        applyStimulus(1, 0, 4'h8, 0, 0, 1);
        idleCycle();
        @(negedge i_clk);
        checkOutput("t5_miss_nack", {31'b0, bus.o_nack}, 32'd1);
        idleCycle();
        idleCycle();
        @(negedge i_clk);
        hold_beats = 1'b0;
        idleCycle();
        applyStimulus(1, 0, 4'h8, 0, 0, 1);
        applyStimulus(1, 0, 4'h8, 0, 0, 1);
        @(negedge i_clk);
        checkOutput("t5_last_beat_nack", {31'b0, bus.o_nack}, 32'd1);
        idleCycle();
        @(negedge i_clk);
        checkOutput("t5_after_nack", {31'b0, bus.o_nack}, 32'd0);
        checkOutput("t5_after_data", bus.o_data, 32'hA4);

        // Reset after the first beat of a refill invalidates everything.
        hold_beats = 1'b1;
        applyStimulus(1, 0, 4'hE, 0, 0, 1);
        idleCycle();
        idleCycle();
        idleCycle();
        @(negedge i_clk);
        hold_beats = 1'b0;
        idleCycle();
        @(negedge i_clk);
        hold_beats = 1'b1;
        @(posedge i_clk);
        #1 i_rst_n = 1'b0;
        @(negedge i_clk);
        checkOutput("t6_reset_nack", {31'b0, bus.o_nack}, 32'd0);
        checkOutput("t6_reset_data", bus.o_data, 32'h0);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n    = 1'b1;
        hold_beats = 1'b0;
        applyStimulus(1, 0, 4'h8, 0, 0, 1);
        idleCycle();
        @(negedge i_clk);
        checkOutput("t6_refill_nack", {31'b0, bus.o_nack}, 32'd1);
        waitFill("t6");
        applyStimulus(1, 0, 4'h8, 0, 0, 1);
        idleCycle();
        @(negedge i_clk);
        checkOutput("t6_hit_data", bus.o_data, 32'hA4);

        idleCycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
